jzjpcc_memory_arbiter: RTL and testbench

- Shares the core's single external memory port between instruction fetch and the memory-stage load/store path.
- Sequences each transaction with a req/ack handshake against variable-latency memory.
- Returns read data to the winning requester.
- Drives per-stage stall requests consumed by the pipeline hazard/stall logic.
- Data accesses win by default; a starvation counter guarantees fetch forward progress.

---
 rtl/jzjpcc_memory_arbiter.sv | 106 ++++++++++
 tb/tb_jzjpcc_memory_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_memory_arbiter.sv
// Shares the single external memory port between instruction fetch and the load/store path.
// Data accesses win by default; a saturating starvation counter forces a fetch grant.
module jzjpcc_memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetchReq,
    input  logic [31:0] fetchAddr,
    output logic [31:0] fetchData,
    output logic        fetchValid,
    input  logic        dataReq,
    input  logic        dataWrite,
    input  logic [31:0] dataAddr,
    input  logic [31:0] dataWriteData,
    input  logic [3:0]  dataByteEnable,
    output logic [31:0] dataReadData,
    output logic        dataValid,
    output logic        memReq,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    output logic [3:0]  memByteEnable,
    input  logic        memAck,
    input  logic [31:0] memReadData,
    output logic        stall_fetch,
    output logic        stall_memory
);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
    typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_t;

    state_t     state;
    owner_t     owner;
    logic [3:0] starve_count;
    logic       fetch_wins;

    // Fetch only beats a pending data request once data has starved it long enough.
    assign fetch_wins   = fetchReq & (~dataReq | (starve_count == STARVE_MAX));
    assign stall_fetch  = fetchReq & ~fetchValid;
    assign stall_memory = dataReq & ~dataValid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= OWNER_FETCH;
            starve_count  <= 4'd0;
            memReq        <= 1'b0;
            memWrite      <= 1'b0;
            memAddr       <= 32'd0;
            memWriteData  <= 32'd0;
            memByteEnable <= 4'd0;
            fetchValid    <= 1'b0;
            dataValid     <= 1'b0;
            fetchData     <= 32'd0;
            dataReadData  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_wins) begin
                        owner         <= OWNER_FETCH;
                        memReq        <= 1'b1;
                        memWrite      <= 1'b0;
                        memAddr       <= fetchAddr;
                        memWriteData  <= 32'd0;
                        memByteEnable <= 4'b1111;
                        starve_count  <= 4'd0;
                        state         <= GRANT;
                    end else if (dataReq) begin
                        owner         <= OWNER_DATA;
                        memReq        <= 1'b1;
                        memWrite      <= dataWrite;
                        memAddr       <= dataAddr;
                        memWriteData  <= dataWriteData;
                        memByteEnable <= dataWrite ? dataByteEnable : 4'b1111;
                        if (fetchReq && (starve_count != STARVE_MAX))
                            starve_count <= starve_count + 4'd1;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    // Bus held stable; requester inputs are not looked at until completion.
                    if (memAck) begin
                        memReq <= 1'b0;
                        state  <= DONE;
                        if (owner == OWNER_FETCH) begin
                            fetchData  <= memReadData;
                            fetchValid <= 1'b1;
                        end else begin
                            if (!memWrite)
                                dataReadData <= memReadData;
                            dataValid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    fetchValid <= 1'b0;
                    dataValid  <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jzjpcc_memory_arbiter.sv
// Bench for jzjpcc_memory_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_jzjpcc_memory_arbiter;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetchReq, dataReq, dataWrite, memAck;
    logic [31:0] fetchAddr, dataAddr, dataWriteData, memReadData;
    logic [3:0]  dataByteEnable;
    logic [31:0] fetchData, dataReadData, memAddr, memWriteData;
    logic        fetchValid, dataValid, memReq, memWrite;
    logic [3:0]  memByteEnable;
    logic        stall_fetch, stall_memory;

    jzjpcc_memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchData(fetchData), .fetchValid(fetchValid),
        .dataReq(dataReq), .dataWrite(dataWrite), .dataAddr(dataAddr),
        .dataWriteData(dataWriteData), .dataByteEnable(dataByteEnable),
        .dataReadData(dataReadData), .dataValid(dataValid),
        .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWriteData(memWriteData),
        .memByteEnable(memByteEnable), .memAck(memAck), .memReadData(memReadData),
        .stall_fetch(stall_fetch), .stall_memory(stall_memory)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Transaction-level model: 0 = free, 1 = transaction outstanding, 2 = completion cycle
    int          m_phase = 0;
    bit          m_fetch_owner;
    logic [31:0] e_addr, e_wdata, e_fdata, e_ddata;
    logic        e_write;
    logic [3:0]  e_be;
    int          starve = 0;
    int          ack_wait = 0;

    int          forced_lat = -1;
    bit          forced_rdata_en = 0;
    logic [31:0] forced_rdata = 32'd0;
    bit          auto_f = 0, auto_d = 0, stray_all = 0;
    int unsigned p_raise = 40;
    bit          starve_mode = 0, armed = 0;
    int          data_run = 0, sm_fetch_grants = 0;

    task automatic evaluate();
        case (m_phase)
            0: if (fetchReq || dataReq) begin
                m_fetch_owner = fetchReq && (!dataReq || starve == LIMIT);
                if (m_fetch_owner) begin
                    e_addr = fetchAddr; e_write = 1'b0; e_wdata = 32'd0; e_be = 4'hF;
                    starve = 0;
                    if (armed) check("starve_run", 32'(data_run), 32'(LIMIT));
                    if (starve_mode) sm_fetch_grants++;
                    armed = starve_mode;
                    data_run = 0;
                end else begin
                    e_addr = dataAddr; e_write = dataWrite; e_wdata = dataWriteData;
                    e_be = dataWrite ? dataByteEnable : 4'hF;
                    if (fetchReq && starve < LIMIT) starve++;
                    data_run++;
                end
                ack_wait = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
                m_phase = 1;
            end
            1: if (memAck) begin
                if (m_fetch_owner) e_fdata = memReadData;
                else if (!e_write) e_ddata = memReadData;
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
        check("memReq", 32'(memReq), 32'(m_phase == 1));
        if (m_phase == 1) begin
            check("memAddr", memAddr, e_addr);
            check("memWrite", 32'(memWrite), 32'(e_write));
            check("memWriteData", memWriteData, e_wdata);
            check("memByteEnable", 32'(memByteEnable), 32'(e_be));
        end
        check("fetchValid", 32'(fetchValid), 32'(m_phase == 2 && m_fetch_owner));
        check("dataValid", 32'(dataValid), 32'(m_phase == 2 && !m_fetch_owner));
        check("fetchData", fetchData, e_fdata);
        check("dataReadData", dataReadData, e_ddata);
    endtask

    task automatic drive();
        if (m_phase == 1) begin
            memAck = (ack_wait == 0);
            memReadData = (forced_rdata_en && ack_wait == 0) ? forced_rdata : $urandom;
            if (ack_wait > 0) ack_wait--;
        end else begin
            memAck = stray_all ? 1'b1 : ($urandom_range(0, 3) == 0);
            memReadData = $urandom;
        end
        if (m_phase == 2) begin
            if (m_fetch_owner) fetchReq = 1'b0;
            else dataReq = 1'b0;
        end
        if (!fetchReq && auto_f && !(m_phase == 2 && m_fetch_owner) && $urandom_range(0, 99) < p_raise) begin
            fetchReq = 1'b1;
            fetchAddr = $urandom & 32'hFFFF_FFFC;
        end
        if (!dataReq && auto_d && !(m_phase == 2 && !m_fetch_owner) && $urandom_range(0, 99) < p_raise) begin
            dataReq = 1'b1;
            dataWrite = 1'($urandom);
            dataAddr = $urandom;
            dataWriteData = $urandom;
            dataByteEnable = 4'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
        evaluate();
        drive();
        #1;
        check("stall_fetch", 32'(stall_fetch), 32'(fetchReq && !(m_phase == 2 && m_fetch_owner)));
        check("stall_memory", 32'(stall_memory), 32'(dataReq && !(m_phase == 2 && !m_fetch_owner)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_memReq"}, 32'(memReq), 32'd0);
        check({tag, "_memWrite"}, 32'(memWrite), 32'd0);
        check({tag, "_memAddr"}, memAddr, 32'd0);
        check({tag, "_memWriteData"}, memWriteData, 32'd0);
        check({tag, "_memByteEnable"}, 32'(memByteEnable), 32'd0);
        check({tag, "_fetchValid"}, 32'(fetchValid), 32'd0);
        check({tag, "_dataValid"}, 32'(dataValid), 32'd0);
        check({tag, "_fetchData"}, fetchData, 32'd0);
        check({tag, "_dataReadData"}, dataReadData, 32'd0);
    endtask

    task automatic model_reset();
        m_phase = 0; starve = 0; e_fdata = 32'd0; e_ddata = 32'd0;
        armed = 0; data_run = 0;
    endtask

    initial begin
        reset = 1'b1;
        fetchReq = 1'b0; dataReq = 1'b0; dataWrite = 1'b0; memAck = 1'b0;
        fetchAddr = 32'd0; dataAddr = 32'd0; dataWriteData = 32'd0;
        dataByteEnable = 4'd0; memReadData = 32'd0;
        e_fdata = 32'd0; e_ddata = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // Fetch-only read with ack three cycles after memReq
        forced_lat = 3; forced_rdata_en = 1; forced_rdata = 32'h0000_0013;
        fetchReq = 1'b1; fetchAddr = 32'h100;
        repeat (8) tick();
        check("fetch_only_data", fetchData, 32'h0000_0013);
        forced_rdata_en = 0;

        // Simultaneous requests, zero-latency ack: data goes first
        forced_lat = 0;
        fetchReq = 1'b1; fetchAddr = 32'h40;
        dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 32'h2000;
        repeat (10) tick();

        // Store held on the bus across five wait cycles
        forced_lat = 5;
        dataReq = 1'b1; dataWrite = 1'b1; dataAddr = 32'h3004;
        dataWriteData = 32'hDEAD_BEEF; dataByteEnable = 4'b0011;
        repeat (12) tick();

        // Stray acks with nothing requested
        stray_all = 1;
        repeat (6) tick();
        stray_all = 0;

        // Starvation: both requesters keep asking
        forced_lat = -1; p_raise = 100; auto_f = 1; auto_d = 1; starve_mode = 1;
        repeat (150) tick();
        starve_mode = 0; armed = 0;
        check("starve_fetch_grants", 32'(sm_fetch_grants >= 3), 32'd1);

        // Random traffic
        p_raise = 40;
        repeat (1500) tick();

        // Reset in the middle of an outstanding transaction
        auto_f = 0; auto_d = 0;
        for (int i = 0; i < 40 && m_phase != 0; i++) tick();
        forced_lat = 20;
        fetchReq = 1'b1; fetchAddr = 32'h0000_0ABC;
        dataReq = 1'b0;
        for (int i = 0; i < 10 && m_phase != 1; i++) tick();
        check("pre_reset_memReq", 32'(memReq), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        fetchReq = 1'b0; dataReq = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        memAck = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            check("late_ack_memReq", 32'(memReq), 32'd0);
            check("late_ack_fetchValid", 32'(fetchValid), 32'd0);
            check("late_ack_dataValid", 32'(dataValid), 32'd0);
        end
        memAck = 1'b0;

        // Traffic again after recovery
        forced_lat = -1; auto_f = 1; auto_d = 1;
        repeat (200) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
